// File: rtl/vo_stream_packer.sv
// Video pixel stream packer: groups PACK pixels into one word and queues
// words with frame/line markers in a small output FIFO.
module vo_stream_packer #(
  parameter int PIX_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    vsync_i,
  input  logic                    de_i,
  input  logic [PIX_W-1:0]        pix_i,
  input  logic                    mode_i,
  input  logic [15:0]             exp_width_i,
  output logic [PACK*PIX_W-1:0]   word_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic                    word_sof_o,
  output logic                    word_eol_o,
  output logic [15:0]             frame_cnt_o,
  output logic [15:0]             line_cnt_o,
  output logic                    err_len_o,
  output logic                    overflow_o
);

  localparam int W  = PACK * PIX_W;
  localparam int LW = $clog2(PACK);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST_C = LW'(PACK - 1);
  localparam logic [AW:0]   FULL_C = (AW + 1)'(FIFO_DEPTH);

  logic            vsync_q;
  logic            de_q;
  logic [LW-1:0]   lane;
  logic [W-1:0]    acc;
  logic [15:0]     pix_cnt;
  logic            sof_pend;
  logic            stg_vld;
  logic            stg_feol;
  logic [W-1:0]    stg_word;

  logic [W+1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;

  logic            vs_rise;
  logic            line_end;
  logic            lane_last;
  logic [PIX_W-1:0] pix_m;
  logic [W-1:0]    acc_nxt;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic            drop;
  logic [W+1:0]    head;

  assign vs_rise   = vsync_i & ~vsync_q;
  assign line_end  = ~de_i & de_q;
  assign lane_last = (lane == LAST_C);
  assign pix_m     = mode_i ? {PIX_W{|pix_i}} : pix_i;
  assign acc_nxt   = acc | ({{(W-PIX_W){1'b0}}, pix_m} << (lane * PIX_W));

  assign full  = (cnt == FULL_C);
  assign pop   = word_valid_o & word_ready_i;
  assign wr_en = stg_vld & (~full | pop);
  assign drop  = stg_vld & full & ~pop;
  assign head  = mem[rd_ptr];

  assign word_valid_o = (cnt != '0);
  assign word_o       = word_valid_o ? head[W-1:0] : '0;
  assign word_eol_o   = word_valid_o & head[W];
  assign word_sof_o   = word_valid_o & head[W+1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      lane        <= '0;
      acc         <= '0;
      pix_cnt     <= '0;
      sof_pend    <= 1'b0;
      stg_vld     <= 1'b0;
      stg_feol    <= 1'b0;
      stg_word    <= '0;
      frame_cnt_o <= '0;
      line_cnt_o  <= '0;
      err_len_o   <= 1'b0;
    end else begin
      vsync_q  <= vsync_i;
      de_q     <= de_i;
      stg_vld  <= 1'b0;
      stg_feol <= 1'b0;
      // the stage word drains every cycle, so a frame start never blocks it
      sof_pend <= vs_rise | (sof_pend & ~stg_vld);
      if (vs_rise) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
        line_cnt_o  <= '0;
        pix_cnt     <= '0;
        lane        <= '0;
        acc         <= '0;
        err_len_o   <= 1'b0;
      end else if (de_i) begin
        if (pix_cnt != 16'hFFFF)
          pix_cnt <= pix_cnt + 16'd1;
        if (lane_last) begin
          stg_vld  <= 1'b1;
          stg_word <= acc_nxt;
          acc      <= '0;
          lane     <= '0;
        end else begin
          acc  <= acc_nxt;
          lane <= lane + 1'b1;
        end
      end else if (line_end) begin
        line_cnt_o <= line_cnt_o + 16'd1;
        pix_cnt    <= '0;
        if (pix_cnt != exp_width_i)
          err_len_o <= 1'b1;
        if (lane != '0) begin
          stg_vld  <= 1'b1;
          stg_word <= acc;
          stg_feol <= 1'b1;
        end
        lane <= '0;
        acc  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {sof_pend, stg_feol | ~de_i, stg_word};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_en & ~pop: cnt <= cnt + 1'b1;
        pop & ~wr_en: cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
      if (vs_rise)
        overflow_o <= 1'b0;
      if (drop)
        overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vo_stream_packer.sv
// Scoreboard bench for vo_stream_packer: a packing model queues expected
// words as lines are driven; a monitor pops and compares accepted words.
module tb_vo_stream_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vsync_i;
  logic        de_i;
  logic [7:0]  pix_i;
  logic        mode_i;
  logic [15:0] exp_width_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        word_sof_o;
  logic        word_eol_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] line_cnt_o;
  logic        err_len_o;
  logic        overflow_o;

  vo_stream_packer #(.PIX_W(8), .PACK(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .vsync_i      (vsync_i),
    .de_i         (de_i),
    .pix_i        (pix_i),
    .mode_i       (mode_i),
    .exp_width_i  (exp_width_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_sof_o   (word_sof_o),
    .word_eol_o   (word_eol_o),
    .frame_cnt_o  (frame_cnt_o),
    .line_cnt_o   (line_cnt_o),
    .err_len_o    (err_len_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_cyc = -1;
  int p4_cyc = 0;
  int rdy_mode = 1;
  bit sof_next = 1'b0;
  logic [33:0] q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    word_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       word_ready_i = 1'b0;
        1:       word_ready_i = 1'b1;
        default: word_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rstn && word_valid_o) begin
      if (fv_cyc < 0)
        fv_cyc = cyc;
      if (word_ready_i) begin
        if (q.size() == 0)
          check("unexpected_word", {30'd0, word_sof_o, word_eol_o, word_o}, 64'h0);
        else
          check("word", {30'd0, word_sof_o, word_eol_o, word_o},
                {30'd0, q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    @(posedge clk);
    #1 vsync_i = 1'b1;
    sof_next = 1'b1;
    @(posedge clk);
    #1 vsync_i = 1'b0;
    idle(2);
  endtask

  task automatic send_line(input int n, input bit mode, input int max_exp,
                           input bit rnd, input int base);
    logic [7:0]  px [256];
    logic [7:0]  v;
    logic [31:0] w;
    int nw;
    for (int i = 0; i < n; i++)
      px[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (k * 4 + j < n) begin
          v = px[k * 4 + j];
          if (mode)
            v = (v != 0) ? 8'hFF : 8'h00;
          w = w | (32'(v) << (8 * j));
        end
      end
      if (k < max_exp)
        q.push_back({sof_next, (k == nw - 1), w});
      sof_next = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      de_i = 1'b1;
      pix_i = px[i];
      mode_i = mode;
      if (i == 3)
        p4_cyc = cyc;
    end
    @(posedge clk);
    #1;
    de_i = 1'b0;
    pix_i = '0;
    idle(3);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || word_valid_o) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", 64'(t >= 300), 64'd0);
    check("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    vsync_i = 1'b0;
    de_i = 1'b0;
    pix_i = '0;
    mode_i = 1'b0;
    exp_width_i = 16'd8;
    idle(3);
    @(negedge clk);
    check("rst_valid", 64'(word_valid_o), 64'd0);
    check("rst_word", 64'(word_o), 64'd0);
    check("rst_sof", 64'(word_sof_o), 64'd0);
    check("rst_eol", 64'(word_eol_o), 64'd0);
    check("rst_frame", 64'(frame_cnt_o), 64'd0);
    check("rst_line", 64'(line_cnt_o), 64'd0);
    check("rst_err", 64'(err_len_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    rdy_mode = 1;
    frame_start();
    check("frame1", 64'(frame_cnt_o), 64'd1);
    fv_cyc = -1;
    send_line(8, 1'b0, 99, 1'b0, 1);
    check("latency", 64'(fv_cyc), 64'(p4_cyc + 2));
    drain();
    check("line1", 64'(line_cnt_o), 64'd1);
    check("err_8", 64'(err_len_o), 64'd0);

    frame_start();
    exp_width_i = 16'd6;
    send_line(6, 1'b0, 99, 1'b0, 1);
    drain();
    check("err_6ok", 64'(err_len_o), 64'd0);
    check("line_6ok", 64'(line_cnt_o), 64'd1);
    exp_width_i = 16'd8;
    send_line(6, 1'b0, 99, 1'b0, 1);
    drain();
    check("err_set", 64'(err_len_o), 64'd1);
    exp_width_i = 16'd6;
    send_line(6, 1'b0, 99, 1'b0, 1);
    drain();
    check("err_sticky", 64'(err_len_o), 64'd1);
    check("line_3", 64'(line_cnt_o), 64'd3);
    frame_start();
    check("err_clr", 64'(err_len_o), 64'd0);
    check("line_clr", 64'(line_cnt_o), 64'd0);

    exp_width_i = 16'd4;
    send_line(1, 1'b1, 99, 1'b0, 0);
    q.delete();
    frame_start();
    q.push_back({1'b1, 1'b1, 32'hFF00FF00});
    sof_next = 1'b0;
    begin
      logic [7:0] mp [4];
      mp[0] = 8'h00; mp[1] = 8'h05; mp[2] = 8'h00; mp[3] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        de_i = 1'b1;
        pix_i = mp[i];
        mode_i = 1'b1;
      end
      @(posedge clk);
      #1 de_i = 1'b0;
      mode_i = 1'b0;
      idle(3);
    end
    drain();
    check("frame_mask", 64'(frame_cnt_o), 64'd4);

    rdy_mode = 0;
    frame_start();
    exp_width_i = 16'd24;
    send_line(24, 1'b0, 4, 1'b0, 16);
    idle(2);
    check("ovf_set", 64'(overflow_o), 64'd1);
    check("ovf_valid", 64'(word_valid_o), 64'd1);
    check("ovf_sof", 64'(word_sof_o), 64'd1);
    check("ovf_head", 64'(word_o), 64'h13121110);
    rdy_mode = 1;
    drain();
    check("ovf_sticky", 64'(overflow_o), 64'd1);

    rdy_mode = 0;
    exp_width_i = 16'd4;
    send_line(4, 1'b0, 99, 1'b0, 40);
    check("pre_rst_valid", 64'(word_valid_o), 64'd1);
    check("pre_rst_frame", 64'(frame_cnt_o), 64'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      de_i = 1'b1;
      pix_i = 8'(i + 7);
    end
    @(posedge clk);
    #1 rstn = 1'b0;
    de_i = 1'b0;
    q.delete();
    @(negedge clk);
    check("mrst_valid", 64'(word_valid_o), 64'd0);
    check("mrst_word", 64'(word_o), 64'd0);
    check("mrst_frame", 64'(frame_cnt_o), 64'd0);
    check("mrst_line", 64'(line_cnt_o), 64'd0);
    check("mrst_ovf", 64'(overflow_o), 64'd0);
    check("mrst_eol", 64'(word_eol_o), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    rdy_mode = 1;
    idle(2);
    check("post_rst_valid", 64'(word_valid_o), 64'd0);
    frame_start();
    check("post_rst_frame", 64'(frame_cnt_o), 64'd1);
    send_line(4, 1'b0, 99, 1'b0, 100);
    drain();

    rdy_mode = 2;
    frame_start();
    for (int l = 0; l < 8; l++) begin
      int n;
      n = $urandom_range(1, 20);
      exp_width_i = 16'(n);
      send_line(n, l[0], 99, 1'b1, 0);
      idle(8);
    end
    drain();
    check("rnd_err", 64'(err_len_o), 64'd0);
    check("rnd_ovf", 64'(overflow_o), 64'd0);
    check("rnd_lines", 64'(line_cnt_o), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
